// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Takes a little-endian byte stream (16-bit word count, then words).
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic [ADDR_W-1:0]     waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [3:0]            wen_o,
    output logic                  core_hold_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t                r_state;
    logic [15:0]           r_count;
    logic [1:0]            r_byte_cnt;
    logic [7:0]            r_csum;
    logic [ADDR_W-1:0]     r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wen;
    logic                  r_ready;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_err;

    logic                  w_xfer;
    logic [15:0]           w_len;
    logic                  w_last;

    assign w_xfer = byte_valid_i && r_ready;
    assign w_len  = {byte_data_i, r_count[7:0]};
    // Index is held (not advanced) after the final word so waddr_o never wraps at DEPTH.
    assign w_last = (16'(r_waddr) == (r_count - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_wen      <= '0;
            r_ready    <= 1'b0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        r_state    <= S_LEN0;
                        r_ready    <= 1'b1;
                        r_hold     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_waddr    <= '0;
                        r_byte_cnt <= '0;
                        r_csum     <= '0;
                    end
                end
                S_LEN0: begin
                    if (w_xfer) begin
                        r_count[7:0] <= byte_data_i;
                        r_state      <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_xfer) begin
                        r_count[15:8] <= byte_data_i;
                        if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= S_CHK;
`else
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
`endif
                        end else if (w_len > DEPTH16) begin
                            r_state <= S_ERR;
                            r_ready <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        case (r_byte_cnt)
                            2'd0:    r_wdata[7:0]   <= byte_data_i;
                            2'd1:    r_wdata[15:8]  <= byte_data_i;
                            2'd2:    r_wdata[23:16] <= byte_data_i;
                            default: r_wdata[31:24] <= byte_data_i;
                        endcase
                        r_csum     <= r_csum ^ byte_data_i;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= S_WRITE;
                            r_ready <= 1'b0;
                            r_wen   <= 4'hF;
                        end
                    end
                end
                S_WRITE: begin
                    r_wen <= '0;
                    if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state <= S_CHK;
                        r_ready <= 1'b1;
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_hold  <= 1'b0;
`endif
                    end else begin
                        r_waddr <= r_waddr + 1'b1;
                        r_state <= S_DATA;
                        r_ready <= 1'b1;
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_ready <= 1'b0;
                        if (byte_data_i == r_csum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_wen   <= '0;
                    r_hold  <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready_o = r_ready;
    assign waddr_o      = r_waddr;
    assign wdata_o      = r_wdata;
    assign wen_o        = r_wen;
    assign core_hold_o  = r_hold;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule
